// File: rtl/spi_slave_responder_if.sv
// Pin- and handshake-level bundle between the SPI responder and its surroundings.
// The slave modport is the responder's view; master is the driving side (pads + TX source + RX sink).
interface spi_slave_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk_i;
    logic                  cs_ni;
    logic                  mosi_i;
    logic                  miso_o;
    logic                  miso_oe_o;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_valid_o;
    logic                  underrun_o;
    logic                  frame_err_o;
    logic [7:0]            word_cnt_o;
    logic                  busy_o;

    modport slave (
        input  sclk_i, cs_ni, mosi_i, tx_data_i, tx_valid_i,
        output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               underrun_o, frame_err_o, word_cnt_o, busy_o
    );

    modport master (
        output sclk_i, cs_ni, mosi_i, tx_data_i, tx_valid_i,
        input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
               underrun_o, frame_err_o, word_cnt_o, busy_o
    );
endinterface

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI responder: oversampled sclk/cs_n/mosi, one-cycle RX strobe per word,
// single-entry TX holding register with valid/ready, IDLE_WORD on underrun.
module spi_slave_responder #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    spi_slave_responder_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] settle_q, settle_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   armed_q, armed_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-2:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             word_cnt_q, word_cnt_d;
    logic                   reload_pending_q, reload_pending_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;

    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise_sclk, fall_sclk, rise_cs, fall_cs;
    logic                   consume, accept;
    logic [DATA_WIDTH-1:0]  next_word;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign rise_sclk = sclk_s & ~sclk_prev_q;
    assign fall_sclk = ~sclk_s & sclk_prev_q;
    assign rise_cs   = cs_s & ~cs_prev_q;
    // A frame may only start once cs_n has been seen high at the pin since reset,
    // so a cs_n still held low across reset never opens a frame on its own.
    assign fall_cs   = ~cs_s & cs_prev_q & armed_q;

    always_comb begin : sync_comb
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_ni};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_i};
        settle_d    = {settle_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        armed_d     = armed_q | (settle_q[SYNC_STAGES-1] & cs_s);
    end

    assign next_word = hold_full_q ? hold_q : IDLE_WORD;
    assign accept    = bus.tx_valid_i & ~hold_full_q;

    always_comb begin : fsm_comb
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        tx_shift_d       = tx_shift_q;
        rx_shift_d       = rx_shift_q;
        rx_data_d        = rx_data_q;
        word_cnt_d       = word_cnt_q;
        reload_pending_d = reload_pending_q;
        rx_valid_d       = 1'b0;
        underrun_d       = 1'b0;
        frame_err_d      = 1'b0;
        consume          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall_cs) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_shift_d       = next_word;
                consume          = hold_full_q;
                underrun_d       = ~hold_full_q;
                bit_cnt_d        = '0;
                word_cnt_d       = '0;
                reload_pending_d = 1'b0;
                state_d          = rise_cs ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                // cs_n release wins over any sclk edge seen in the same cycle
                if (rise_cs) begin
                    state_d          = ST_IDLE;
                    frame_err_d      = (bit_cnt_q != '0);
                    bit_cnt_d        = '0;
                    reload_pending_d = 1'b0;
                    tx_shift_d       = '0;
                end else if (rise_sclk) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        rx_data_d        = {rx_shift_q, mosi_s};
                        rx_valid_d       = 1'b1;
                        bit_cnt_d        = '0;
                        reload_pending_d = 1'b1;
                        if (word_cnt_q != 8'hFF) word_cnt_d = word_cnt_q + 8'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (fall_sclk) begin
                    if (reload_pending_q) begin
                        tx_shift_d       = next_word;
                        consume          = hold_full_q;
                        underrun_d       = ~hold_full_q;
                        reload_pending_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // consume needs a full register and accept an empty one, so they never collide
    always_comb begin : hold_comb
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (consume) hold_full_d = 1'b0;
        if (accept) begin
            hold_d      = bus.tx_data_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sclk_sync_q      <= '0;
            cs_sync_q        <= '1;
            mosi_sync_q      <= '0;
            settle_q         <= '0;
            sclk_prev_q      <= 1'b0;
            cs_prev_q        <= 1'b1;
            armed_q          <= 1'b0;
            state_q          <= ST_IDLE;
            bit_cnt_q        <= '0;
            tx_shift_q       <= '0;
            rx_shift_q       <= '0;
            rx_data_q        <= '0;
            rx_valid_q       <= 1'b0;
            underrun_q       <= 1'b0;
            frame_err_q      <= 1'b0;
            word_cnt_q       <= '0;
            reload_pending_q <= 1'b0;
            hold_q           <= '0;
            hold_full_q      <= 1'b0;
        end else begin
            sclk_sync_q      <= sclk_sync_d;
            cs_sync_q        <= cs_sync_d;
            mosi_sync_q      <= mosi_sync_d;
            settle_q         <= settle_d;
            sclk_prev_q      <= sclk_prev_d;
            cs_prev_q        <= cs_prev_d;
            armed_q          <= armed_d;
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            tx_shift_q       <= tx_shift_d;
            rx_shift_q       <= rx_shift_d;
            rx_data_q        <= rx_data_d;
            rx_valid_q       <= rx_valid_d;
            underrun_q       <= underrun_d;
            frame_err_q      <= frame_err_d;
            word_cnt_q       <= word_cnt_d;
            reload_pending_q <= reload_pending_d;
            hold_q           <= hold_d;
            hold_full_q      <= hold_full_d;
        end
    end

    assign bus.miso_o      = tx_shift_q[DATA_WIDTH-1];
    assign bus.miso_oe_o   = (state_q != ST_IDLE);
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.tx_ready_o  = ~hold_full_q;
    assign bus.rx_data_o   = rx_data_q;
    assign bus.rx_valid_o  = rx_valid_q;
    assign bus.underrun_o  = underrun_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.word_cnt_o  = word_cnt_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: constant vector table, directed multi-cycle sequences,
// and random frames checked against a word-level model of the TX holding register.
module tb_spi_slave_responder;
    localparam int         DW     = 8;
    localparam logic [7:0] IDLE_W = 8'h00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_responder_if #(.DATA_WIDTH(DW)) bus();

    spi_slave_responder #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2),
        .IDLE_WORD  (IDLE_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rise_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor
    logic [7:0] rx_log[$];
    int underrun_cnt = 0, ferr_cnt = 0, rx_cnt = 0, last_valid_cyc = 0;
    always @(negedge clk) begin
        if (bus.rx_valid_o) begin
            rx_log.push_back(bus.rx_data_o);
            rx_cnt         <= rx_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (bus.underrun_o)  underrun_cnt <= underrun_cnt + 1;
        if (bus.frame_err_o) ferr_cnt     <= ferr_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        int waited = 0;
        while (!bus.tx_ready_o && waited < 64) begin
            tick(1);
            waited++;
        end
        check("push_ready", 32'(bus.tx_ready_o), 32'd1);
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        tick(1);
        bus.tx_valid_i = 1'b0;
    endtask

    // word-level model: one holding slot, every word load empties it or falls back to IDLE_W
    logic       model_full = 1'b0;
    logic [7:0] model_hold = 8'h00;

    task automatic model_push(input logic [7:0] d);
        push_tx(d);
        model_full = 1'b1;
        model_hold = d;
    endtask

    task automatic model_load(output logic [7:0] w, output int was_underrun);
        if (model_full) begin
            w = model_hold;
            model_full = 1'b0;
            was_underrun = 0;
        end else begin
            w = IDLE_W;
            was_underrun = 1;
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.sclk_i = 1'b0;
            bus.mosi_i = d[7-i];
            tick(4);
            got = {got[6:0], bus.miso_o};
            bus.sclk_i = 1'b1;
            rise_cyc   = cyc;
            tick(4);
        end
    endtask

    task automatic frame_start();
        bus.cs_ni = 1'b0;
        tick(8);
    endtask

    task automatic frame_end(input string tag);
        bus.cs_ni  = 1'b1;
        bus.sclk_i = 1'b0;
        bus.mosi_i = 1'b0;
        tick(6);
        check({tag, "_oe_off"}, 32'(bus.miso_oe_o), 32'd0);
        check({tag, "_busy_off"}, 32'(bus.busy_o), 32'd0);
    endtask

    task automatic check_rx_log(input string tag, input logic [7:0] exp_q[$]);
        check({tag, "_rx_count"}, 32'(rx_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), 32'(rx_log[i]), 32'(exp_q[i]));
    endtask

    typedef struct {
        logic       preload;
        logic [7:0] tx;
        logic [7:0] mosi;
        int         nbits;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx_data;
        int         exp_valid;
        int         exp_under;
        int         exp_ferr;
        int         exp_wcnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] got, got2, em, md;
        logic [7:0] exp_q[$];
        int u0, f0, r0, nw, nb, wu, exp_u, accepted;
        bit abort;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8, 8'hA5, 8'h3C, 1, 0, 0, 1};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8, 8'h00, 8'hFF, 1, 1, 0, 1};
        vecs[2] = '{1'b1, 8'hC3, 8'h81, 8, 8'hC3, 8'h81, 1, 0, 0, 1};
        vecs[3] = '{1'b1, 8'h96, 8'hF0, 5, 8'h12, 8'h81, 0, 0, 1, 0};
        vecs[4] = '{1'b0, 8'h00, 8'h5A, 8, 8'h00, 8'h5A, 1, 1, 0, 1};

        bus.sclk_i = 1'b0; bus.cs_ni = 1'b1; bus.mosi_i = 1'b0;
        bus.tx_data_i = 8'h00; bus.tx_valid_i = 1'b0;

        // reset state
        tick(4);
        check("rst_miso", 32'(bus.miso_o), 32'd0);
        check("rst_oe", 32'(bus.miso_oe_o), 32'd0);
        check("rst_ready", 32'(bus.tx_ready_o), 32'd1);
        check("rst_rxdata", 32'(bus.rx_data_o), 32'd0);
        check("rst_wcnt", 32'(bus.word_cnt_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        rst_n = 1'b1;
        tick(6);

        // table-driven single-word frames
        for (int v = 0; v < 5; v++) begin
            u0 = underrun_cnt; f0 = ferr_cnt; r0 = rx_cnt;
            if (vecs[v].preload) push_tx(vecs[v].tx);
            frame_start();
            check($sformatf("v%0d_oe_on", v), 32'(bus.miso_oe_o), 32'd1);
            send_bits(vecs[v].mosi, vecs[v].nbits, got);
            frame_end($sformatf("v%0d", v));
            check($sformatf("v%0d_miso", v), 32'(got), 32'(vecs[v].exp_miso));
            check($sformatf("v%0d_valid", v), 32'(rx_cnt - r0), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_rxdata", v), 32'(bus.rx_data_o), 32'(vecs[v].exp_rx_data));
            check($sformatf("v%0d_underrun", v), 32'(underrun_cnt - u0), 32'(vecs[v].exp_under));
            check($sformatf("v%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_wcnt", v), 32'(bus.word_cnt_o), 32'(vecs[v].exp_wcnt));
            if (v == 0) check("v0_latency", 32'(last_valid_cyc - rise_cyc), 32'd3);
        end

        // multi-word frame, TX fed as tx_ready rises
        rx_log.delete(); u0 = underrun_cnt;
        push_tx(8'h11);
        frame_start();
        send_bits(8'hDE, 8, got);  check("mw_miso0", 32'(got), 32'h11);
        push_tx(8'h22);
        send_bits(8'hAD, 8, got);  check("mw_miso1", 32'(got), 32'h22);
        push_tx(8'h33);
        send_bits(8'hBE, 8, got);  check("mw_miso2", 32'(got), 32'h33);
        frame_end("mw");
        exp_q = '{8'hDE, 8'hAD, 8'hBE};
        check_rx_log("mw", exp_q);
        check("mw_wcnt", 32'(bus.word_cnt_o), 32'd3);
        check("mw_underrun", 32'(underrun_cnt - u0), 32'd0);

        // reset in the middle of a frame, cs_n still low afterwards
        u0 = underrun_cnt; f0 = ferr_cnt; r0 = rx_cnt;
        push_tx(8'h3E);
        frame_start();
        send_bits(8'hA0, 3, got);
        rst_n = 1'b0;
        tick(2);
        check("mr_miso", 32'(bus.miso_o), 32'd0);
        check("mr_oe", 32'(bus.miso_oe_o), 32'd0);
        check("mr_ready", 32'(bus.tx_ready_o), 32'd1);
        check("mr_rxdata", 32'(bus.rx_data_o), 32'd0);
        check("mr_wcnt", 32'(bus.word_cnt_o), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.sclk_i = 1'b0; tick(4);
            bus.sclk_i = 1'b1; tick(4);
        end
        check("mr_busy_after", 32'(bus.busy_o), 32'd0);
        bus.cs_ni = 1'b1; bus.sclk_i = 1'b0;
        tick(6);
        check("mr_no_valid", 32'(rx_cnt - r0), 32'd0);
        check("mr_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("mr_underrun", 32'(underrun_cnt - u0), 32'd0);
        r0 = rx_cnt;
        push_tx(8'h6B);
        frame_start();
        send_bits(8'hC5, 8, got);
        frame_end("mr2");
        check("mr2_miso", 32'(got), 32'h6B);
        check("mr2_valid", 32'(rx_cnt - r0), 32'd1);
        check("mr2_rxdata", 32'(bus.rx_data_o), 32'hC5);

        // tx_valid held while the holding register is full
        rx_log.delete(); u0 = underrun_cnt;
        push_tx(8'h44);
        bus.tx_data_i  = 8'h77;
        bus.tx_valid_i = 1'b1;
        tick(5);
        check("hold_ready_low", 32'(bus.tx_ready_o), 32'd0);
        bus.cs_ni = 1'b0;
        accepted = 0;
        for (int i = 0; i < 20 && accepted == 0; i++) begin
            tick(1);
            if (bus.tx_ready_o) begin
                tick(1);
                bus.tx_valid_i = 1'b0;
                accepted = 1;
            end
        end
        bus.tx_valid_i = 1'b0;
        check("hold_accepted", 32'(accepted), 32'd1);
        check("hold_full_again", 32'(bus.tx_ready_o), 32'd0);
        tick(4);
        send_bits(8'h12, 8, got);
        send_bits(8'h34, 8, got2);
        frame_end("hold");
        check("hold_miso0", 32'(got), 32'h44);
        check("hold_miso1", 32'(got2), 32'h77);
        check("hold_underrun", 32'(underrun_cnt - u0), 32'd0);
        exp_q = '{8'h12, 8'h34};
        check_rx_log("hold", exp_q);

        // random frames against the word-level model
        model_full = 1'b0;
        for (int f = 0; f < 25; f++) begin
            nw    = $urandom_range(1, 3);
            abort = ($urandom_range(0, 3) == 0);
            exp_u = 0;
            exp_q.delete();
            rx_log.delete();
            u0 = underrun_cnt; f0 = ferr_cnt;
            if ($urandom_range(0, 1) == 1) model_push(8'($urandom));
            frame_start();
            for (int j = 0; j < nw; j++) begin
                if (j > 0 && $urandom_range(0, 1) == 1) model_push(8'($urandom));
                nb = (abort && j == nw - 1) ? $urandom_range(1, 7) : 8;
                model_load(em, wu);
                exp_u += wu;
                md = 8'($urandom);
                send_bits(md, nb, got);
                check($sformatf("rnd%0d_miso%0d", f, j), 32'(got), 32'(em >> (8 - nb)));
                if (nb == 8) exp_q.push_back(md);
            end
            frame_end($sformatf("rnd%0d", f));
            check_rx_log($sformatf("rnd%0d", f), exp_q);
            check($sformatf("rnd%0d_underrun", f), 32'(underrun_cnt - u0), 32'(exp_u));
            check($sformatf("rnd%0d_ferr", f), 32'(ferr_cnt - f0), abort ? 32'd1 : 32'd0);
            check($sformatf("rnd%0d_wcnt", f), 32'(bus.word_cnt_o), 32'(exp_q.size()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the far end of the team's SPI master link, and for loopback verification of that master on the board.
- Fully synchronous to clk_i. sclk, cs_n and mosi are oversampled through synchronizers and edge-detected.
- Delivers each received byte with a one-cycle valid strobe.
- Transmits bytes from a single-entry TX holding register with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop stages on sclk_i, cs_ni and mosi_i (minimum 2).
- IDLE_WORD, 8'h00, word shifted out when the TX holding register is empty at word load.

Ports:
- clk_i  in  1  system clock; must be at least 4x the SPI sclk frequency.
- rst_i  in  1  reset, synchronous, active-low.
- sclk_i  in  1  SPI clock from master (asynchronous).
- cs_ni  in  1  chip select, active-low (asynchronous).
- mosi_i  in  1  serial data from master.
- miso_o  out  1  serial data to master.
- miso_oe_o  out  1  output enable for the miso pad; high while selected.
- tx_data_i  in  DATA_WIDTH  word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  TX holding register is empty.
- rx_data_o  out  DATA_WIDTH  last received word.
- rx_valid_o  out  1  one-cycle strobe, rx_data_o updated.
- underrun_o  out  1  one-cycle strobe, IDLE_WORD was loaded.
- frame_err_o  out  1  one-cycle strobe, cs_n released mid-word.
- word_cnt_o  out  8  words completed in the current frame; saturates at 255.
- busy_o  out  1  high while selected.

Behaviour:
- **Reset (rst_i=0 at a clk_i edge):**
  - All synchronizers are loaded with the idle values: sclk=0, cs_n=1, mosi=0.
  - State = IDLE, bit_cnt=0, TX holding register empty.
  - miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, underrun_o=0, frame_err_o=0, word_cnt_o=0, busy_o=0.
  - Reset mid-frame aborts the frame silently: no strobes, and the next frame starts only on a new cs_n falling edge.
- **Edge detection:** performed on the last synchronizer stage versus its registered copy (rise_sclk, fall_sclk, fall_cs, rise_cs).
- **State machine (IDLE, LOAD, SHIFT):**
  - IDLE: miso_oe_o=0, busy_o=0. fall_cs -> LOAD.
  - LOAD (1 cycle):
    - tx_shift <= holding register if full (register becomes empty), else IDLE_WORD with underrun_o pulsed.
    - miso_o <= MSB of the loaded word; bit_cnt=0; word_cnt_o=0; miso_oe_o=1, busy_o=1.
    - -> SHIFT.
  - SHIFT:
    - rise_sclk: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit_cnt++.
      - If bit_cnt reaches DATA_WIDTH: rx_data_o <= assembled word, rx_valid_o=1 for that cycle, word_cnt_o++ (saturating), bit_cnt=0, and reload_pending is set.
    - fall_sclk with reload_pending: load the next word from the holding register or IDLE_WORD (underrun_o pulsed), drive its MSB, clear reload_pending.
    - fall_sclk otherwise: tx_shift shifts left and miso_o = new MSB.
    - rise_cs -> IDLE.
- **cs_n release (rise_cs):**
  - If bit_cnt != 0: frame_err_o pulses for 1 cycle and the partial word is discarded (no rx_valid_o).
  - Always: miso_oe_o=0 on the following cycle.
  - The holding register is kept; an unsent word stays for the next frame.
- **Simultaneous events:**
  - rise_cs takes priority over a same-cycle sclk edge; the edge is ignored.
  - A tx_valid_i accept in the same cycle as a load is not used for that load; it fills the now-empty register.
- **TX handshake:**
  - Transfer occurs when tx_valid_i && tx_ready_o at a clk_i edge.
  - tx_ready_o falls the next cycle and rises the cycle after the register is consumed.
  - tx_valid_i while tx_ready_o=0 is ignored; the upstream block holds it.
- **Latency:** rx_valid_o asserts SYNC_STAGES+1 clk_i cycles after the DATA_WIDTH-th sclk rising edge at the pin.
- **RX:** no back-pressure. rx_data_o holds its value until the next word completes.

Test Plan:
1. **Single word with TX preloaded.** Reset, accept tx_data_i=8'hA5, master (sclk=clk_i/8) sends 8'h3C.
   -> rx_data_o=8'h3C with one rx_valid_o pulse; master samples 8'hA5 on miso; word_cnt_o=1; underrun_o stays 0.
2. **Underrun.** No TX word loaded, master sends 8'hFF.
   -> miso shifts 8'h00 (IDLE_WORD); underrun_o pulses exactly once at LOAD; rx_data_o=8'hFF.
3. **Multi-word frame.** Feed TX words 8'h11, 8'h22, 8'h33 as tx_ready_o rises; master sends 8'hDE, 8'hAD, 8'hBE in one cs_n frame.
   -> three rx_valid_o pulses in order; master reads 11/22/33; word_cnt_o=3.
4. **Mid-word abort.** Raise cs_n after 5 sclk rising edges.
   -> frame_err_o pulses once; no rx_valid_o; miso_oe_o=0.
   -> Next frame sending 8'h5A receives 8'h5A cleanly.
5. **Reset mid-frame.** Assert rst_i=0 for 2 cycles after 3 bits.
   -> all outputs at reset values, no strobes; the next frame works normally.
6. **Handshake hold.** tx_valid_i held high with 8'h77 while the register is full.
   -> no overwrite of the held word; 8'h77 is accepted only after the next load empties the register.
